serial_capture_ctrl: RTL and testbench

//  Sequences a 14-bit serial-in shift register with enable to capture words from an SPI-style ADC.

---
 rtl/mda_capture_pkg.sv | 17 +
 rtl/shift_reg_en.sv | 26 ++
 rtl/serial_capture_ctrl.sv | 163 ++++++++++++++++
 tb/tb_serial_capture_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mda_capture_pkg.sv
// rtl/mda_capture_pkg.sv - shared state encodings and default constants for the serial capture slice
// Purpose: FSM state type and default frame geometry used by serial_capture_ctrl and its bench.
// Ports: none (package).
package mda_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } cap_state_t;

    localparam int DEF_WIDTH    = 14;
    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_CS_SETUP = 2;

endpackage

// File: rtl/shift_reg_en.sv
// rtl/shift_reg_en.sv - generic serial-in shift register with enable
// Purpose: shifts d into bit 0 on every enabled clock; MSB-first words end up right-aligned.
// Ports: clk, resetn (async, active-low), enable, d (serial in), q[WIDTH-1:0] (parallel out).
module shift_reg_en #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_q <= '0;
        end else if (enable) begin
            r_q <= {r_q[WIDTH-2:0], d};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/serial_capture_ctrl.sv
// rtl/serial_capture_ctrl.sv - SPI-style ADC frame sequencer with valid/ready word output
// Purpose: drives cs_n/sclk for one WIDTH-bit frame per start, captures sdi on each sclk rise,
//          and presents the word on data/data_valid; a word finishing while the slot is full is
//          dropped and flagged on the sticky overrun output.
// Ports: clk, resetn (async, active-low), start, sdi, sclk, cs_n, busy, data[WIDTH-1:0],
//        data_valid, data_ready, overrun, overrun_count[7:0] (OVERRUN_CNT_EN only), ovr_clr.
// Build option: define OVERRUN_CNT_EN to add the saturating overrun_count output.
module serial_capture_ctrl
    import mda_capture_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int CS_SETUP = DEF_CS_SETUP
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             sdi,
    output logic             sclk,
    output logic             cs_n,
    output logic             busy,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
`ifdef OVERRUN_CNT_EN
    output logic [7:0]       overrun_count,
`endif
    input  logic             ovr_clr
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int SU_W  = $clog2(CS_SETUP + 1);
    localparam int BIT_W = $clog2(WIDTH + 1);

    cap_state_t        r_state;
    cap_state_t        w_state_nxt;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [SU_W-1:0]   r_setup_cnt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic              r_sclk;
    logic              r_cs_n;
    logic [WIDTH-1:0]  r_data;
    logic              r_data_valid;
    logic              r_overrun;
    logic              w_div_wrap;
    logic              w_shift_en;
    logic              w_slot_free;
    logic              w_drop;
    logic [WIDTH-1:0]  w_shreg;

    shift_reg_en #(.WIDTH(WIDTH)) u_shreg (
        .clk    (clk),
        .resetn (resetn),
        .enable (w_shift_en),
        .d      (sdi),
        .q      (w_shreg)
    );

    assign w_div_wrap  = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    // A held word may still leave in the DONE cycle, freeing the slot for the new one.
    assign w_slot_free = !r_data_valid || data_ready;
    assign w_drop      = (r_state == ST_DONE) && !w_slot_free;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                if (r_setup_cnt == SU_W'(CS_SETUP - 1)) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                // End of a low half: sclk is about to rise, capture sdi at the same edge.
                // End of the last high half: frame complete.
                if (w_div_wrap) begin
                    if (!r_sclk) begin
                        w_shift_en = 1'b1;
                    end else if (r_bit_cnt == BIT_W'(WIDTH - 1)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_div_cnt    <= '0;
            r_setup_cnt  <= '0;
            r_bit_cnt    <= '0;
            r_sclk       <= 1'b0;
            r_cs_n       <= 1'b1;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Registered from next state so cs_n is low for exactly the SETUP and SHIFT cycles.
            r_cs_n  <= !((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_SHIFT));

            if (r_state == ST_SETUP) r_setup_cnt <= r_setup_cnt + 1'b1;
            else                     r_setup_cnt <= '0;

            if (r_state == ST_SHIFT) begin
                r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
                if (w_div_wrap) begin
                    r_sclk <= !r_sclk;
                    if (r_sclk) r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end else begin
                r_div_cnt <= '0;
                r_bit_cnt <= '0;
                r_sclk    <= 1'b0;
            end

            if ((r_state == ST_DONE) && w_slot_free) begin
                r_data       <= w_shreg;
                r_data_valid <= 1'b1;
            end else if (r_data_valid && data_ready) begin
                r_data_valid <= 1'b0;
            end

            // A new drop beats a simultaneous clear.
            if (w_drop)       r_overrun <= 1'b1;
            else if (ovr_clr) r_overrun <= 1'b0;
        end
    end

`ifdef OVERRUN_CNT_EN
    logic [7:0] r_ovr_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ovr_cnt <= 8'd0;
        end else if (w_drop) begin
            if (ovr_clr)                r_ovr_cnt <= 8'd1;
            else if (r_ovr_cnt != 8'hFF) r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end else if (ovr_clr) begin
            r_ovr_cnt <= 8'd0;
        end
    end

    assign overrun_count = r_ovr_cnt;
`endif

    assign sclk       = r_sclk;
    assign cs_n       = r_cs_n;
    assign busy       = (r_state != ST_IDLE);
    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_serial_capture_ctrl.sv
// tb/tb_serial_capture_ctrl.sv - self-checking bench for serial_capture_ctrl
module tb_serial_capture_ctrl;

    localparam int WIDTH    = 14;
    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int P_DONE   = CS_SETUP + 2 * CLK_DIV * WIDTH;
    localparam int PERIOD   = P_DONE + 2;

    logic             clk = 1'b0;
    logic             resetn = 1'b1;
    logic             start = 1'b0;
    logic             sdi = 1'b0;
    logic             sclk;
    logic             cs_n;
    logic             busy;
    logic [WIDTH-1:0] data;
    logic             data_valid;
    logic             data_ready = 1'b0;
    logic             overrun;
    logic             ovr_clr = 1'b0;
`ifdef OVERRUN_CNT_EN
    logic [7:0]       ovr_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;

    serial_capture_ctrl #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .sdi           (sdi),
        .sclk          (sclk),
        .cs_n          (cs_n),
        .busy          (busy),
        .data          (data),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .overrun       (overrun),
`ifdef OVERRUN_CNT_EN
        .overrun_count (ovr_cnt),
`endif
        .ovr_clr       (ovr_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: m_t is the number of cycles since the frame's start was accepted
    // (-1 when idle); outputs follow from where m_t sits in the frame timeline.
    int               m_t = -1;
    logic [WIDTH-1:0] m_word = '0;
    logic [WIDTH-1:0] next_word = '0;
    logic [WIDTH-1:0] m_data = '0;
    bit               m_dv = 1'b0;
    bit               m_ovr = 1'b0;
    int               m_cnt = 0;
    bit               m_hs;
    bit               m_drop;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_t = -1; m_dv = 1'b0; m_data = '0; m_ovr = 1'b0; m_cnt = 0;
        end else begin
            m_hs   = m_dv && data_ready;
            m_drop = 1'b0;
            if (m_t == P_DONE) begin
                if (!m_dv || m_hs) begin
                    m_data = m_word;
                    m_dv   = 1'b1;
                end else begin
                    m_drop = 1'b1;
                end
                m_t = -1;
            end else begin
                if (m_hs) m_dv = 1'b0;
                if (m_t >= 0) m_t++;
                else if (start) begin
                    m_t    = 0;
                    m_word = next_word;
                end
            end
            if (m_drop) begin
                m_ovr = 1'b1;
                m_cnt = ovr_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            end else if (ovr_clr) begin
                m_ovr = 1'b0;
                m_cnt = 0;
            end
        end
    end

    // ADC pin model: MSB valid once cs_n falls, next bit presented after each sclk rise.
    int   adc_idx = WIDTH - 1;
    logic adc_prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (cs_n) adc_idx = WIDTH - 1;
        else if (sclk && !adc_prev_sclk) adc_idx--;
        adc_prev_sclk = sclk;
        sdi = (adc_idx >= 0) ? m_word[adc_idx] : 1'b0;
    end

    int e_sclk;
    always @(negedge clk) begin
        e_sclk = (m_t >= CS_SETUP && m_t < P_DONE) ? (((m_t - CS_SETUP) / CLK_DIV) % 2) : 0;
        chk("busy", 32'(busy), 32'(m_t >= 0));
        chk("cs_n", 32'(cs_n), 32'(!(m_t >= 0 && m_t < P_DONE)));
        chk("sclk", 32'(sclk), 32'(e_sclk));
        chk("data_valid", 32'(data_valid), 32'(m_dv));
        chk("data", 32'(data), 32'(m_data));
        chk("overrun", 32'(overrun), 32'(m_ovr));
`ifdef OVERRUN_CNT_EN
        chk("overrun_count", 32'(ovr_cnt), 32'(m_cnt));
`endif
    end

    task automatic start_frame(input logic [WIDTH-1:0] w);
        @(negedge clk); #1;
        next_word = w; start = 1'b1; t0 = cyc;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 400 && busy; i++) @(negedge clk);
        if (busy) begin
            n_checks++; n_fail++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles", i);
        end
    endtask

    int   rises, lows, nr, glitch;
    logic ps, pdv;
    int   rise_t[4];

    initial begin
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_cs_n", 32'(cs_n), 32'd1);
        chk("reset_data", 32'(data), 32'd0);

        // 1: reset while the 7th bit is being shifted
        data_ready = 1'b1;
        start_frame(14'h1B6D);
        rises = 0; ps = 1'b0;
        for (int i = 0; i < 200 && rises < 7; i++) begin
            @(negedge clk);
            if (sclk && !ps) rises++;
            ps = sclk;
        end
        chk("t1_reached_bit7", 32'(rises), 32'd7);
        #1 resetn = 1'b0;
        #1;
        chk("t1_sclk", 32'(sclk), 32'd0);
        chk("t1_cs_n", 32'(cs_n), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_dv", 32'(data_valid), 32'd0);
        @(negedge clk); #1 resetn = 1'b1;
        start_frame(14'h15A3);
        wait_idle();
        @(negedge clk);
        chk("t1_clean_data", 32'(data), 32'h15A3);

        // 2: latency, sclk rise count, cs_n low time
        repeat (3) @(negedge clk);
        start_frame(14'h2A5C);
        rises = 0; lows = 1; ps = 1'b0;
        for (int i = 0; i < 200 && !data_valid; i++) begin
            @(negedge clk);
            if (sclk && !ps) rises++;
            ps = sclk;
            if (!cs_n) lows++;
        end
        chk("t2_data", 32'(data), 32'h2A5C);
        chk("t2_latency", 32'(cyc - t0), 32'd116);
        chk("t2_sclk_rises", 32'(rises), 32'd14);
        chk("t2_cs_low", 32'(lows), 32'd114);

        // 3: slot full, second frame dropped; clear coincides with the drop
        repeat (3) @(negedge clk);
        #1 data_ready = 1'b0;
        start_frame(14'h0001);
        wait_idle();
        start_frame(14'h3FFF);
        while (cyc < t0 + 115) @(negedge clk);
        #1 ovr_clr = 1'b1;
        @(negedge clk); #1 ovr_clr = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("t3_data_held", 32'(data), 32'h0001);
        chk("t3_overrun", 32'(overrun), 32'd1);
        #1 ovr_clr = 1'b1;
        @(negedge clk);
        chk("t3_ovr_clr", 32'(overrun), 32'd0);
        #1 ovr_clr = 1'b0;

        // 4: accept in the DONE cycle, reload at the same edge
        start_frame(14'h1234);
        while (cyc < t0 + 115) @(negedge clk);
        #1 data_ready = 1'b1;
        @(negedge clk);
        chk("t4_data", 32'(data), 32'h1234);
        chk("t4_dv", 32'(data_valid), 32'd1);
        chk("t4_overrun", 32'(overrun), 32'd0);
        #1 data_ready = 1'b0;

        // 5: start held high
        @(negedge clk); #1;
        data_ready = 1'b1; next_word = 14'($urandom); start = 1'b1;
        nr = 0; glitch = 0; pdv = data_valid;
        for (int i = 0; i < 700 && nr < 4; i++) begin
            @(negedge clk);
            if (data_valid && !pdv) begin rise_t[nr] = cyc; nr++; end
            pdv = data_valid;
            if (sclk && cs_n) glitch++;
            #1 next_word = 14'($urandom);
        end
        chk("t5_rises", 32'(nr), 32'd4);
        chk("t5_period_a", 32'(rise_t[2] - rise_t[1]), 32'(PERIOD));
        chk("t5_period_b", 32'(rise_t[3] - rise_t[2]), 32'(PERIOD));
        chk("t5_glitch", 32'(glitch), 32'd0);
        start = 1'b0;
        wait_idle();

        // random traffic
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk); #1;
            start      = ($urandom_range(0, 5) == 0);
            data_ready = $urandom_range(0, 1) == 1;
            ovr_clr    = ($urandom_range(0, 29) == 0);
            next_word  = 14'($urandom);
        end
        start = 1'b0; ovr_clr = 1'b0; data_ready = 1'b1;
        wait_idle();

        // 6: >300 dropped frames
        @(negedge clk); #1 ovr_clr = 1'b1;
        @(negedge clk); #1 ovr_clr = 1'b0; data_ready = 1'b0; start = 1'b1;
        t0 = cyc;
        while (cyc < t0 + 302 * PERIOD) begin
            @(negedge clk); #1 next_word = 14'($urandom);
        end
        start = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("t6_overrun", 32'(overrun), 32'd1);
`ifdef OVERRUN_CNT_EN
        chk("t6_count_sat", 32'(ovr_cnt), 32'hFF);
`endif
        #1 ovr_clr = 1'b1;
        @(negedge clk);
        chk("t6_clr_overrun", 32'(overrun), 32'd0);
`ifdef OVERRUN_CNT_EN
        chk("t6_clr_count", 32'(ovr_cnt), 32'd0);
`endif
        #1 ovr_clr = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
